// File: rtl/writeback_queue_if.sv
// Writeback port bundle: ALU and long-latency result inputs, register-file write
// output, forwarding lookup and FIFO occupancy.
interface writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          aluValid;
  logic [AW-1:0] aluRegister;
  logic [DW-1:0] aluData;
  logic          longValid;
  logic          longReady;
  logic [AW-1:0] longRegister;
  logic [DW-1:0] longData;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeBack;
  logic          RegisterWrite;
  logic [AW-1:0] lookupRegister;
  logic          lookupHit;
  logic [DW-1:0] lookupData;
  logic [CW-1:0] count;

  modport slave (
    input  aluValid, aluRegister, aluData,
    input  longValid, longRegister, longData,
    input  lookupRegister,
    output longReady, writeRegister, writeBack, RegisterWrite,
    output lookupHit, lookupData, count
  );

  modport master (
    output aluValid, aluRegister, aluData,
    output longValid, longRegister, longData,
    output lookupRegister,
    input  longReady, writeRegister, writeBack, RegisterWrite,
    input  lookupHit, lookupData, count
  );
endinterface

// File: rtl/writeback_queue.sv
// Merges ALU and buffered long-latency results into one register write per cycle (1-cycle registered issue).
// ALU has no backpressure and wins the port; long path is held off only by longReady (= !full).
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  writeback_queue_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    ent_reg [DEPTH];
  logic [DW-1:0]    ent_dat [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  logic          wr_en_q;
  logic [AW-1:0] wr_reg_q;
  logic [DW-1:0] wr_dat_q;

  logic full;
  logic nonempty;
  logic alu_wr;
  logic push;
  logic pop;
  logic pop_issue;

  assign full      = (cnt == CW'(DEPTH));
  assign nonempty  = (cnt != '0);
  assign alu_wr    = bus.aluValid && (bus.aluRegister != '0);
  assign push      = bus.longValid && !full && (bus.longRegister != '0);
  // A squashed head is retired only in a cycle the ALU leaves the write port idle.
  assign pop       = nonempty && !alu_wr;
  assign pop_issue = pop && ent_vld[rd_ptr];

  // Squash hits every slot holding aluRegister; the incoming push is set afterwards so it survives.
  always_comb begin
    vld_nxt = ent_vld;
    if (pop) vld_nxt[rd_ptr] = 1'b0;
    if (alu_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_reg[i] == bus.aluRegister) vld_nxt[i] = 1'b0;
      end
    end
    if (push) vld_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      ent_vld <= vld_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_ptr] <= bus.longRegister;
      ent_dat[wr_ptr] <= bus.longData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q  <= 1'b0;
      wr_reg_q <= '0;
      wr_dat_q <= '0;
    end else if (alu_wr) begin
      wr_en_q  <= 1'b1;
      wr_reg_q <= bus.aluRegister;
      wr_dat_q <= bus.aluData;
    end else if (pop_issue) begin
      wr_en_q  <= 1'b1;
      wr_reg_q <= ent_reg[rd_ptr];
      wr_dat_q <= ent_dat[rd_ptr];
    end else begin
      wr_en_q  <= 1'b0;
    end
  end

  // Forwarding: evaluate oldest source first so each younger match overrides it.
  logic [PW-1:0] idx;
  always_comb begin
    bus.lookupHit  = 1'b0;
    bus.lookupData = '0;
    idx            = '0;
    if (bus.lookupRegister != '0) begin
      if (wr_en_q && (wr_reg_q == bus.lookupRegister)) begin
        bus.lookupHit  = 1'b1;
        bus.lookupData = wr_dat_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PW'(k);
        if ((CW'(k) < cnt) && ent_vld[idx] && (ent_reg[idx] == bus.lookupRegister)) begin
          bus.lookupHit  = 1'b1;
          bus.lookupData = ent_dat[idx];
        end
      end
      if (alu_wr && (bus.aluRegister == bus.lookupRegister)) begin
        bus.lookupHit  = 1'b1;
        bus.lookupData = bus.aluData;
      end
    end
  end

  assign bus.longReady     = !full;
  assign bus.count         = cnt;
  assign bus.RegisterWrite = wr_en_q;
  assign bus.writeRegister = wr_reg_q;
  assign bus.writeBack     = wr_dat_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: issue priority, FIFO order, squash, lookup and async reset.
module tb_writeback_queue;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  writeback_queue_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

  writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.aluValid    = v;
    bus.aluRegister = r;
    bus.aluData     = d;
  endtask

  task automatic lng(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.longValid    = v;
    bus.longRegister = r;
    bus.longData     = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    alu(1'b0, 5'd0, 32'h0);
    lng(1'b0, 5'd0, 32'h0);
    bus.lookupRegister = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    32'(bus.RegisterWrite), 32'd0);
    chk("rst_wreg",  32'(bus.writeRegister), 32'd0);
    chk("rst_wdat",  bus.writeBack,          32'd0);
    chk("rst_count", 32'(bus.count),         32'd0);
    chk("rst_rdy",   32'(bus.longReady),     32'd1);
    rst = 1'b1;
    tick();

    // single ALU write, 1-cycle latency
    alu(1'b1, 5'd5, 32'hA5);
    tick();
    chk("alu_we",   32'(bus.RegisterWrite), 32'd1);
    chk("alu_wreg", 32'(bus.writeRegister), 32'd5);
    chk("alu_wdat", bus.writeBack,          32'hA5);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    chk("alu_we_off", 32'(bus.RegisterWrite), 32'd0);
    chk("alu_hold",   32'(bus.writeRegister), 32'd5);

    // fill the FIFO while the ALU holds the port
    for (int i = 1; i <= 4; i++) begin
      alu(1'b1, 5'd9, 32'h900 + 32'(i));
      lng(1'b1, 5'(i), 32'(i) * 32'h11);
      tick();
    end
    chk("full_count", 32'(bus.count),     32'd4);
    chk("full_rdy",   32'(bus.longReady), 32'd0);
    chk("full_wreg",  32'(bus.writeRegister), 32'd9);
    lng(1'b1, 5'd6, 32'h66);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    chk("pop1_we",    32'(bus.RegisterWrite), 32'd1);
    chk("pop1_wreg",  32'(bus.writeRegister), 32'd1);
    chk("pop1_wdat",  bus.writeBack,          32'h11);
    chk("pop1_count", 32'(bus.count),         32'd3);
    chk("pop1_rdy",   32'(bus.longReady),     32'd1);
    lng(1'b0, 5'd0, 32'h0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("popn_we",    32'(bus.RegisterWrite), 32'd1);
      chk("popn_wreg",  32'(bus.writeRegister), 32'(i));
      chk("popn_wdat",  bus.writeBack,          32'(i) * 32'h11);
      chk("popn_count", 32'(bus.count),         32'(4 - i));
    end
    tick();
    chk("drain_we", 32'(bus.RegisterWrite), 32'd0);

    // squash of a queued entry by a younger ALU write
    lng(1'b1, 5'd7, 32'h70);
    tick();
    chk("sq_count1", 32'(bus.count), 32'd1);
    lng(1'b0, 5'd0, 32'h0);
    alu(1'b1, 5'd7, 32'h99);
    tick();
    chk("sq_we",     32'(bus.RegisterWrite), 32'd1);
    chk("sq_wreg",   32'(bus.writeRegister), 32'd7);
    chk("sq_wdat",   bus.writeBack,          32'h99);
    chk("sq_count2", 32'(bus.count),         32'd1);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    chk("sq_bubble", 32'(bus.RegisterWrite), 32'd0);
    chk("sq_count0", 32'(bus.count),         32'd0);
    chk("sq_hold",   bus.writeBack,          32'h99);
    tick();
    chk("sq_idle", 32'(bus.RegisterWrite), 32'd0);

    // six ALU cycles starve the FIFO
    for (int c = 0; c < 6; c++) begin
      alu(1'b1, 5'd10, 32'hA0 + 32'(c));
      if (c == 0)      lng(1'b1, 5'd11, 32'hB1);
      else if (c == 1) lng(1'b1, 5'd12, 32'hB2);
      else             lng(1'b0, 5'd0, 32'h0);
      tick();
      chk("busy_wreg", 32'(bus.writeRegister), 32'd10);
      chk("busy_wdat", bus.writeBack,          32'hA0 + 32'(c));
      if (c >= 1) chk("busy_count", 32'(bus.count), 32'd2);
    end
    alu(1'b0, 5'd0, 32'h0);
    tick();
    chk("busy_d1_wreg",  32'(bus.writeRegister), 32'd11);
    chk("busy_d1_wdat",  bus.writeBack,          32'hB1);
    chk("busy_d1_count", 32'(bus.count),         32'd1);
    tick();
    chk("busy_d2_wreg",  32'(bus.writeRegister), 32'd12);
    chk("busy_d2_wdat",  bus.writeBack,          32'hB2);
    chk("busy_d2_count", 32'(bus.count),         32'd0);
    tick();
    chk("busy_idle", 32'(bus.RegisterWrite), 32'd0);

    // forwarding lookup priority
    alu(1'b1, 5'd9, 32'h909);
    lng(1'b1, 5'd3, 32'h33);
    tick();
    chk("lk_count", 32'(bus.count), 32'd1);
    lng(1'b0, 5'd0, 32'h0);
    alu(1'b0, 5'd0, 32'h0);
    bus.lookupRegister = 5'd3;
    #1;
    chk("lk_fifo_hit",  32'(bus.lookupHit), 32'd1);
    chk("lk_fifo_dat",  bus.lookupData,     32'h33);
    alu(1'b1, 5'd3, 32'h55);
    #1;
    chk("lk_alu_hit", 32'(bus.lookupHit), 32'd1);
    chk("lk_alu_dat", bus.lookupData,     32'h55);
    bus.lookupRegister = 5'd0;
    #1;
    chk("lk_r0_hit", 32'(bus.lookupHit), 32'd0);
    chk("lk_r0_dat", bus.lookupData,     32'd0);
    bus.lookupRegister = 5'd3;
    tick();
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("lk_out_hit", 32'(bus.lookupHit), 32'd1);
    chk("lk_out_dat", bus.lookupData,     32'h55);
    bus.lookupRegister = 5'd8;
    #1;
    chk("lk_miss_hit", 32'(bus.lookupHit), 32'd0);
    chk("lk_miss_dat", bus.lookupData,     32'd0);
    tick();
    chk("lk_drop_we",    32'(bus.RegisterWrite), 32'd0);
    chk("lk_drop_count", 32'(bus.count),         32'd0);
    bus.lookupRegister = 5'd3;
    #1;
    chk("lk_gone_hit", 32'(bus.lookupHit), 32'd0);
    bus.lookupRegister = 5'd0;

    // r0 long result dropped, then async reset with a loaded queue
    for (int i = 0; i < 3; i++) begin
      alu(1'b1, 5'd9, 32'h990 + 32'(i));
      lng(1'b1, 5'(20 + i), 32'hC0 + 32'(i));
      tick();
    end
    chk("ar_count3", 32'(bus.count), 32'd3);
    lng(1'b1, 5'd0, 32'hDEAD);
    tick();
    chk("r0_count", 32'(bus.count),     32'd3);
    chk("r0_rdy",   32'(bus.longReady), 32'd1);
    alu(1'b0, 5'd0, 32'h0);
    lng(1'b0, 5'd0, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(bus.count),         32'd0);
    chk("ar_we",    32'(bus.RegisterWrite), 32'd0);
    chk("ar_rdy",   32'(bus.longReady),     32'd1);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_we",    32'(bus.RegisterWrite), 32'd0);
      chk("post_count", 32'(bus.count),         32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
